// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the ADT7420-style I2C target: FSM states,
// register addresses and the register read mux.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6
  } state_t;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_STATUS   = 8'h02;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;
  localparam logic [7:0] CONFIG_RESET = 8'h00;

  function automatic logic [7:0] reg_read(input logic [7:0] addr,
                                          input logic [7:0] msb,
                                          input logic [7:0] lsb,
                                          input logic       valid,
                                          input logic [7:0] cfg,
                                          input logic [7:0] id);
    logic [7:0] val;
    case (addr)
      REG_TEMP_MSB: val = msb;
      REG_TEMP_LSB: val = lsb;
      REG_STATUS:   val = {~valid, 7'b0000000};
      REG_CONFIG:   val = cfg;
      REG_ID:       val = id;
      default:      val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchronizer, FILT_LEN-sample majority-free glitch filter and
// edge detector for one open-drain bus line. Output and pulses are coincident.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic                sync1;
  logic                sync2;
  logic [FILT_LEN-2:0] hist;
  logic [FILT_LEN-1:0] samples;
  logic                all_hi;
  logic                all_lo;

  // The newest synchronized sample counts toward the window, giving 2+FILT_LEN latency
  always_comb begin
    samples = {hist, sync2};
    all_hi  = &samples;
    all_lo  = ~(|samples);
  end

  // Synchronizer, sample history and filtered level with edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= {(FILT_LEN-1){1'b1}};
      dout  <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      hist  <= samples[FILT_LEN-2:0];
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (all_hi && !dout) begin
        dout <= 1'b1;
        rise <= 1'b1;
      end else if (all_lo && dout) begin
        dout <= 1'b0;
        fall <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating an ADT7420 temperature sensor: auto-incrementing
// register pointer, coherent temperature snapshot per read, writable CONFIG.
module i2c_temp_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter int         FILT_LEN = 3,
  parameter logic [7:0] ID_VALUE = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] temp_i,
  input  logic        temp_valid_i,
  output logic [7:0]  config_o,
  output logic        busy_o
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .din(scl_i), .dout(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .din(sda_i), .dout(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, shift_in;
  logic [7:0] rd_shift, rd_shift_n, rd_live;
  logic [7:0] ptr, ptr_n;
  logic [7:0] cfg, cfg_n;
  logic [7:0] shd_msb, shd_msb_n, shd_lsb, shd_lsb_n;
  logic       shd_valid, shd_valid_n;
  logic       sda_oe, sda_oe_n;
  logic       busy, busy_n;
  logic       rw, rw_n;
  logic       first, first_n;
  logic       ack_on, ack_on_n;

  // Next-state and datapath update; START/STOP override any bit activity
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rd_shift_n  = rd_shift;
    ptr_n       = ptr;
    cfg_n       = cfg;
    shd_msb_n   = shd_msb;
    shd_lsb_n   = shd_lsb;
    shd_valid_n = shd_valid;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    rw_n        = rw;
    first_n     = first;
    ack_on_n    = ack_on;
    start_det   = sda_fall & scl_f;
    stop_det    = sda_rise & scl_f;
    shift_in    = {shift[6:0], sda_f};
    rd_live     = reg_read(ptr, temp_i[15:8], temp_i[7:0], temp_valid_i, cfg, ID_VALUE);

    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shift_in[7:1] == DEV_ADDR) begin
                state_n  = ST_ADDR_ACK;
                rw_n     = shift_in[0];
                ack_on_n = 1'b0;
              end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
              end
            end else begin
              state_n = ST_ADDR;
            end
          end else begin
            state_n = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          busy_n = busy | ack_on;
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_n = 1'b0 | 1'b1;
              ack_on_n = 1'b1;
            end else if (rw) begin
              // Snapshot and first read byte come from the same live sample
              shd_msb_n   = temp_i[15:8];
              shd_lsb_n   = temp_i[7:0];
              shd_valid_n = temp_valid_i;
              rd_shift_n  = rd_live;
              sda_oe_n    = ~rd_live[7];
              bit_cnt_n   = 4'd0;
              state_n     = ST_RD_BYTE;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              first_n   = 1'b1;
              state_n   = ST_WR_BYTE;
            end
          end else begin
            state_n = ST_ADDR_ACK;
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state_n  = ST_WR_ACK;
              ack_on_n = 1'b0;
              first_n  = 1'b0;
              if (first) begin
                ptr_n = shift_in;
              end else begin
                cfg_n = (ptr == REG_CONFIG) ? shift_in : cfg;
                ptr_n = ptr + 8'd1;
              end
            end else begin
              state_n = ST_WR_BYTE;
            end
          end else begin
            state_n = ST_WR_BYTE;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = ST_WR_BYTE;
            end
          end else begin
            state_n = ST_WR_ACK;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr_n    = ptr + 8'd1;
              sda_oe_n = 1'b0;
              ack_on_n = 1'b0;
              state_n  = ST_RD_ACK;
            end else begin
              rd_shift_n = {rd_shift[6:0], 1'b0};
              sda_oe_n   = ~rd_shift[6];
            end
          end else begin
            state_n = ST_RD_BYTE;
          end
        end
        ST_RD_ACK: begin
          // Master ACK reloads now; the first bit goes out on the next SCL fall
          if (scl_rise && !ack_on) begin
            if (!sda_f) begin
              ack_on_n   = 1'b1;
              rd_shift_n = reg_read(ptr, shd_msb, shd_lsb, shd_valid, cfg, ID_VALUE);
            end else begin
              state_n = ST_IDLE;
            end
          end else if (scl_fall && ack_on) begin
            sda_oe_n  = ~rd_shift[7];
            bit_cnt_n = 4'd0;
            state_n   = ST_RD_BYTE;
          end else begin
            state_n = ST_RD_ACK;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rd_shift  <= 8'h00;
      ptr       <= 8'h00;
      cfg       <= CONFIG_RESET;
      shd_msb   <= 8'h00;
      shd_lsb   <= 8'h00;
      shd_valid <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
      first     <= 1'b0;
      ack_on    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      rd_shift  <= rd_shift_n;
      ptr       <= ptr_n;
      cfg       <= cfg_n;
      shd_msb   <= shd_msb_n;
      shd_lsb   <= shd_lsb_n;
      shd_valid <= shd_valid_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      rw        <= rw_n;
      first     <= first_n;
      ack_on    <= ack_on_n;
    end
  end

  assign sda_oe_o = sda_oe;
  assign config_o = cfg;
  assign busy_o   = busy;

endmodule
